// File: rtl/invsqrt_prod_norm_pkg.sv
// Shared widths and types for the inverse-square-root product normaliser.
// The INVSQRT_NORM_RNE_EN macro is consumed by the rounder, not here.
package invsqrt_norm_pkg;

  localparam int PSIZE   = 88;
  localparam int MUL_LAT = 2;
  localparam int OUT_W   = 41;
  localparam int EXP_W   = 11;

  typedef struct packed {
    logic [OUT_W-1:0] man;
    logic [EXP_W-1:0] exp;
    logic             inexact;
    logic             err;
  } norm_res_t;

  typedef struct packed {
    logic             valid;
    logic [EXP_W-1:0] exp;
  } side_t;

endpackage

// File: rtl/invsqrt_prod_norm_if.sv
// Handshake and multiplier-side bus of the product normaliser.
// slave is the normaliser's view; master is the surrounding datapath.
interface invsqrt_prod_norm_if;
  import invsqrt_norm_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [EXP_W-1:0] in_exp;
  logic             mul_ce;
  logic [PSIZE-1:0] mul_p;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_man;
  logic [EXP_W-1:0] out_exp;
  logic             out_inexact;
  logic             out_err;

  modport master (
    output in_valid, in_exp, mul_p, out_ready,
    input  in_ready, mul_ce, out_valid, out_man, out_exp, out_inexact, out_err
  );

  modport slave (
    input  in_valid, in_exp, mul_p, out_ready,
    output in_ready, mul_ce, out_valid, out_man, out_exp, out_inexact, out_err
  );

endinterface

// File: rtl/invsqrt_prod_norm_round.sv
// Combinational mantissa rounder. INVSQRT_NORM_RNE_EN selects round-to-nearest-even;
// without it the kept bits pass through truncated and carry is never raised.
module invsqrt_rne_round
  import invsqrt_norm_pkg::*;
(
  input  logic [OUT_W-1:0] kept,
  input  logic             guard,
  input  logic             sticky,
  output logic [OUT_W-1:0] man,
  output logic             carry
);

`ifdef INVSQRT_NORM_RNE_EN
  logic             inc;
  logic [OUT_W:0]   sum;

  // All-ones mantissa rounding up renormalises to the leading one alone.
  always_comb begin
    inc   = guard & (sticky | kept[0]);
    sum   = {1'b0, kept} + {{OUT_W{1'b0}}, inc};
    carry = sum[OUT_W];
    man   = carry ? {1'b1, {(OUT_W-1){1'b0}}} : sum[OUT_W-1:0];
  end
`else
  logic unused_round;

  assign unused_round = guard | sticky;
  assign man          = kept;
  assign carry        = 1'b0;
`endif

endmodule

// File: rtl/invsqrt_prod_norm.sv
// Normalise/round stage behind the 47x41 mantissa multiplier; stalls the multiplier via mul_ce.
// Rounding mode follows INVSQRT_NORM_RNE_EN (see invsqrt_rne_round).
module invsqrt_prod_norm
  import invsqrt_norm_pkg::*;
(
  input logic                clk,
  input logic                rst,
  invsqrt_prod_norm_if.slave bus
);

  side_t            side [MUL_LAT];
  side_t            last;
  logic             adv;
  logic [OUT_W-1:0] kept;
  logic             guard;
  logic             sticky;
  logic [EXP_W-1:0] norm_exp;
  logic             unnorm;
  logic [OUT_W-1:0] rnd_man;
  logic             rnd_carry;
  norm_res_t        res;
  norm_res_t        out_q;
  logic             out_valid_q;

  assign adv          = ~out_valid_q | bus.out_ready;
  assign bus.mul_ce   = adv | rst;
  assign bus.in_ready = adv;
  assign last         = side[MUL_LAT-1];

  // Sidecar shifts in lockstep with the multiplier so exp/valid meet their product.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MUL_LAT; i++) side[i] <= '0;
    end else if (adv) begin
      side[0] <= '{valid: bus.in_valid, exp: bus.in_exp};
      for (int i = 1; i < MUL_LAT; i++) side[i] <= side[i-1];
    end
  end

  always_comb begin
    kept     = '0;
    guard    = 1'b0;
    sticky   = 1'b0;
    norm_exp = last.exp;
    unnorm   = 1'b0;
    if (bus.mul_p[PSIZE-1]) begin
      kept     = bus.mul_p[PSIZE-1 -: OUT_W];
      guard    = bus.mul_p[PSIZE-1-OUT_W];
      sticky   = |bus.mul_p[PSIZE-2-OUT_W:0];
      norm_exp = last.exp + EXP_W'(1);
    end else if (bus.mul_p[PSIZE-2]) begin
      kept     = bus.mul_p[PSIZE-2 -: OUT_W];
      guard    = bus.mul_p[PSIZE-2-OUT_W];
      sticky   = |bus.mul_p[PSIZE-3-OUT_W:0];
    end else begin
      unnorm   = 1'b1;
    end
  end

  invsqrt_rne_round u_round (
    .kept   (kept),
    .guard  (guard),
    .sticky (sticky),
    .man    (rnd_man),
    .carry  (rnd_carry)
  );

  // Exponent wraps modulo 2^EXP_W; range checking happens downstream.
  always_comb begin
    res.man     = unnorm ? '0 : rnd_man;
    res.exp     = norm_exp + {{(EXP_W-1){1'b0}}, rnd_carry};
    res.inexact = guard | sticky;
    res.err     = unnorm;
  end

  // Empty slots load zeros so stale multiplier contents never show on the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_q       <= '0;
    end else if (adv) begin
      out_valid_q <= last.valid;
      out_q       <= last.valid ? res : '0;
    end
  end

  assign bus.out_valid   = out_valid_q;
  assign bus.out_man     = out_q.man;
  assign bus.out_exp     = out_q.exp;
  assign bus.out_inexact = out_q.inexact;
  assign bus.out_err     = out_q.err;

endmodule
